// File: rtl/csr_axi_cmd_master.sv
// Single-outstanding AXI4 master bridging a valid/ready command port to single-beat
// reads/writes on the CSR slave, with one response per command and a wait-state timeout.
module csr_axi_cmd_master #(
    parameter int unsigned             AXI_ID_WIDTH   = 8,
    parameter int unsigned             AXI_ADDR_WIDTH = 12,
    parameter int unsigned             AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ID_WIDTH-1:0] MST_ID         = 8'h5A,
    parameter int unsigned             TIMEOUT_CYC    = 1024
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_id_err,
    output logic                          rsp_timeout,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]       axi_awid,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                          axi_wlast,
    input  logic                          axi_bvalid,
    output logic                          axi_bready,
    input  logic [1:0]                    axi_bresp,
    input  logic [AXI_ID_WIDTH-1:0]       axi_bid,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]       axi_arid,
    input  logic                          axi_rvalid,
    output logic                          axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic [AXI_ID_WIDTH-1:0]       axi_rid,
    input  logic                          axi_rlast
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RSP} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     tcnt;
    logic                 aw_done, w_done, aw_done_d, w_done_d;
    logic                 cmd_hs, aw_hs, w_hs, ar_hs, r_hs, b_hs, rsp_hs;
    logic                 tmo, abort, wait_state;

    logic                      cmd_ready_d, rsp_valid_d;
    logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_d;
    logic [STRB_W-1:0]         wstrb_d;

    logic unused_rlast;
    assign unused_rlast = axi_rlast;

    assign axi_awid = MST_ID;
    assign axi_arid = MST_ID;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = axi_awvalid & axi_awready;
    assign w_hs   = axi_wvalid & axi_wready;
    assign ar_hs  = axi_arvalid & axi_arready;
    assign r_hs   = axi_rvalid & axi_rready;
    assign b_hs   = axi_bvalid & axi_bready;
    assign rsp_hs = rsp_valid & rsp_ready;
    assign tmo    = (tcnt == CNT_W'(TIMEOUT_CYC - 1));
    assign wait_state = (state == S_AR) || (state == S_R) || (state == S_AW_W) || (state == S_B);

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state   <= S_IDLE;
            tcnt    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
            if (state_next != state)
                tcnt <= '0;
            else if (wait_state)
                tcnt <= tcnt + CNT_W'(1);
        end
    end

    // The awaited handshake is tested before tmo so a last-cycle handshake wins.
    always_comb begin
        state_next = state;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: if (cmd_hs) state_next = cmd_write ? S_AW_W : S_AR;
            S_AR: begin
                if (ar_hs)    state_next = S_R;
                else if (tmo) begin state_next = S_RSP; abort = 1'b1; end
            end
            S_R: begin
                if (r_hs)     state_next = S_RSP;
                else if (tmo) begin state_next = S_RSP; abort = 1'b1; end
            end
            S_AW_W: begin
                aw_done_d = aw_done | aw_hs;
                w_done_d  = w_done | w_hs;
                if (aw_done_d && w_done_d) state_next = S_B;
                else if (tmo)              begin state_next = S_RSP; abort = 1'b1; end
            end
            S_B: begin
                if (b_hs)     state_next = S_RSP;
                else if (tmo) begin state_next = S_RSP; abort = 1'b1; end
            end
            S_RSP: if (rsp_hs) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered; addresses stay
    // valid through the data/response phase for the slave's decoder.
    always_comb begin
        cmd_ready_d = (state_next == S_IDLE);
        rsp_valid_d = (state_next == S_RSP);
        arvalid_d   = (state_next == S_AR);
        rready_d    = (state_next == S_R);
        awvalid_d   = (state_next == S_AW_W) && !aw_done_d;
        wvalid_d    = (state_next == S_AW_W) && !w_done_d;
        bready_d    = (state_next == S_B);
        araddr_d    = '0;
        awaddr_d    = '0;
        wdata_d     = '0;
        wstrb_d     = '0;
        if (state_next == S_AR || state_next == S_R)
            araddr_d = (state == S_IDLE) ? cmd_addr : axi_araddr;
        if (state_next == S_AW_W || state_next == S_B)
            awaddr_d = (state == S_IDLE) ? cmd_addr : axi_awaddr;
        if (wvalid_d) begin
            wdata_d = (state == S_IDLE) ? cmd_wdata : axi_wdata;
            wstrb_d = (state == S_IDLE) ? cmd_wstrb : axi_wstrb;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            axi_bready  <= 1'b0;
            axi_araddr  <= '0;
            axi_awaddr  <= '0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
        end else begin
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            axi_arvalid <= arvalid_d;
            axi_rready  <= rready_d;
            axi_awvalid <= awvalid_d;
            axi_wvalid  <= wvalid_d;
            axi_wlast   <= wvalid_d;
            axi_bready  <= bready_d;
            axi_araddr  <= araddr_d;
            axi_awaddr  <= awaddr_d;
            axi_wdata   <= wdata_d;
            axi_wstrb   <= wstrb_d;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_id_err  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (cmd_hs) begin
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_id_err  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (r_hs) begin
            rsp_rdata   <= axi_rdata;
            rsp_resp    <= axi_rresp;
            rsp_id_err  <= (axi_rid != MST_ID);
            rsp_timeout <= 1'b0;
        end else if (b_hs) begin
            rsp_rdata   <= '0;
            rsp_resp    <= axi_bresp;
            rsp_id_err  <= (axi_bid != MST_ID);
            rsp_timeout <= 1'b0;
        end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_id_err  <= 1'b0;
            rsp_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_csr_axi_cmd_master.sv
// Bench for csr_axi_cmd_master: latency-configurable AXI slave plus a transaction-level
// response model, exercised with directed scenarios and randomized commands.
module tb_csr_axi_cmd_master;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        id_err;
        logic        to;
    } rsp_t;

    logic        aclk, arstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_id_err, rsp_timeout;
    logic        axi_awvalid, axi_awready;
    logic [11:0] axi_awaddr;
    logic [7:0]  axi_awid;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic [7:0]  axi_bid;
    logic        axi_arvalid, axi_arready;
    logic [11:0] axi_araddr;
    logic [7:0]  axi_arid;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic [7:0]  axi_rid;
    logic        axi_rlast;

    csr_axi_cmd_master #(
        .AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32),
        .MST_ID(8'h5A), .TIMEOUT_CYC(TO)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_id_err(rsp_id_err), .rsp_timeout(rsp_timeout),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rid(axi_rid), .axi_rlast(axi_rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [103:0] dut_outs;
    assign dut_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_id_err, rsp_timeout,
                       axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
                       axi_bready, axi_arvalid, axi_araddr, axi_rready};

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration: ready/valid latency in cycles after the master's request; -1 = never
    int          aw_lat, w_lat, ar_lat, b_lat, r_lat;
    logic [7:0]  bid_val, rid_val;
    logic [1:0]  bresp_val, rresp_val;
    logic [31:0] pc_val;

    bit [31:0] slave_mem [1024];
    bit [31:0] ref_mem [1024];

    // Slave: drives its responses on the falling edge from what the master shows.
    initial begin
        int aw_w, w_w, ar_w, b_w, r_w;
        {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_rlast} = '0;
        {axi_bresp, axi_bid, axi_rdata, axi_rresp, axi_rid} = '0;
        {aw_w, w_w, ar_w, b_w, r_w} = '0;
        forever begin
            @(negedge aclk);
            if (!arstn) begin
                {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} = '0;
                {aw_w, w_w, ar_w, b_w, r_w} = '0;
            end else begin
                aw_w = axi_awvalid ? aw_w + 1 : 0;
                w_w  = axi_wvalid  ? w_w + 1  : 0;
                ar_w = axi_arvalid ? ar_w + 1 : 0;
                b_w  = axi_bready  ? b_w + 1  : 0;
                r_w  = axi_rready  ? r_w + 1  : 0;
                axi_awready = axi_awvalid && aw_lat >= 0 && aw_w > aw_lat;
                axi_wready  = axi_wvalid  && w_lat  >= 0 && w_w  > w_lat;
                axi_arready = axi_arvalid && ar_lat >= 0 && ar_w > ar_lat;
                axi_bvalid  = axi_bready  && b_lat  >= 0 && b_w  > b_lat;
                axi_rvalid  = axi_rready  && r_lat  >= 0 && r_w  > r_lat;
                axi_bid   = bid_val;
                axi_bresp = bresp_val;
                axi_rid   = rid_val;
                axi_rresp = rresp_val;
                axi_rlast = 1'($urandom_range(0, 1));
                axi_rdata = (axi_araddr == 12'h00C) ? pc_val : slave_mem[axi_araddr[11:2]];
            end
        end
    end

    // Channel monitor: handshake counts, timing and addresses seen on the bus.
    int          cyc = 0, aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, arv_n = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, b_first_cyc = 0;
    logic        bready_q = 1'b0, wlast_seen = 1'b0;
    logic [11:0] b_awaddr = '0, r_araddr = '0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        bready_q <= axi_bready;
        if (axi_awvalid && axi_awready) begin aw_hs_n <= aw_hs_n + 1; aw_hs_cyc <= cyc; end
        if (axi_wvalid && axi_wready) begin
            w_hs_n <= w_hs_n + 1;
            w_hs_cyc <= cyc;
            wlast_seen <= axi_wlast;
            for (int i = 0; i < 4; i++)
                if (axi_wstrb[i]) slave_mem[axi_awaddr[11:2]][8*i +: 8] <= axi_wdata[8*i +: 8];
        end
        if (axi_arvalid) arv_n <= arv_n + 1;
        if (axi_arvalid && axi_arready) ar_hs_n <= ar_hs_n + 1;
        if (axi_bready && !bready_q) b_first_cyc <= cyc;
        if (axi_bvalid && axi_bready) b_awaddr <= axi_awaddr;
        if (axi_rvalid && axi_rready) r_araddr <= axi_araddr;
    end

    function automatic bit lat_ok(int l);
        return l >= 0 && l < TO;
    endfunction

    // Expected response from the slave settings: each wait phase must complete within TO cycles.
    function automatic rsp_t model(bit w, logic [11:0] a, logic [31:0] d, logic [3:0] s);
        rsp_t e = '0;
        if (w) begin
            if (lat_ok(aw_lat) && lat_ok(w_lat)) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
                if (lat_ok(b_lat)) begin
                    e.resp = bresp_val;
                    e.id_err = (bid_val != 8'h5A);
                end else e.to = 1'b1;
            end else e.to = 1'b1;
        end else begin
            if (lat_ok(ar_lat) && lat_ok(r_lat)) begin
                e.rdata = (a == 12'h00C) ? pc_val : ref_mem[a[11:2]];
                e.resp = rresp_val;
                e.id_err = (rid_val != 8'h5A);
            end else e.to = 1'b1;
        end
        return e;
    endfunction

    task automatic set_nominal();
        {aw_lat, w_lat, ar_lat, b_lat, r_lat} = '0;
        bid_val = 8'h5A; rid_val = 8'h5A; bresp_val = 2'b00; rresp_val = 2'b00;
    endtask

    // Runs one command; reports observed response, completion and stability during a hold of rsp_ready.
    task automatic run_txn(input bit w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output rsp_t r, output bit done, output bit stable);
        int n;
        done = 1'b0; stable = 1'b1; r = '0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(negedge aclk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
        if (!rsp_valid) return;
        r = {rsp_rdata, rsp_resp, rsp_id_err, rsp_timeout};
        repeat (hold) begin
            @(negedge aclk);
            if (!rsp_valid || cmd_ready || {rsp_rdata, rsp_resp, rsp_id_err, rsp_timeout} != r) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        done = !rsp_valid;
    endtask

    task automatic test_reset();
        arstn = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        pc_val = 32'h0;
        set_nominal();
        #2 arstn = 1'b0;
        #3;
        vectors++;
        if (dut_outs !== '0) begin miscompares++; $display("FAIL reset_outs got=%h exp=0", dut_outs); end
        vectors++;
        if ({axi_awid, axi_arid} !== 16'h5A5A) begin
            miscompares++; $display("FAIL reset_ids got=%h exp=5a5a", {axi_awid, axi_arid});
        end
        @(negedge aclk); arstn = 1'b1;
        repeat (2) @(negedge aclk);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write_read();
        rsp_t r, e; bit done, st; int aw0, w0;
        set_nominal();
        aw0 = aw_hs_n; w0 = w_hs_n;
        e = model(1'b1, 12'h004, 32'h02100123, 4'hF);
        run_txn(1'b1, 12'h004, 32'h02100123, 4'hF, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t1_wr_rsp got=%h done=%0d exp=%h", r, done, e); end
        vectors++;
        if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin
            miscompares++; $display("FAIL t1_beats aw=%0d w=%0d exp=1/1", aw_hs_n - aw0, w_hs_n - w0);
        end
        vectors++;
        if (b_awaddr !== 12'h004 || wlast_seen !== 1'b1) begin
            miscompares++; $display("FAIL t1_awaddr_at_b got=%h wlast=%b exp=004/1", b_awaddr, wlast_seen);
        end
        e = model(1'b0, 12'h004, '0, '0);
        run_txn(1'b0, 12'h004, '0, '0, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t2_rd_rsp got=%h done=%0d exp=%h", r, done, e); end
        pc_val = $urandom;
        e = model(1'b0, 12'h00C, '0, '0);
        run_txn(1'b0, 12'h00C, '0, '0, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t2_pc_rsp got=%h done=%0d exp=%h", r, done, e); end
        vectors++;
        if (r_araddr !== 12'h00C) begin miscompares++; $display("FAIL t2_araddr_at_r got=%h exp=00c", r_araddr); end
    endtask

    task automatic test_aw_w_order();
        rsp_t r, e; bit done, st; int aw0, w0; logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            set_nominal();
            aw_lat = (k == 0) ? 0 : 3;
            w_lat  = (k == 0) ? 3 : 0;
            d = $urandom;
            aw0 = aw_hs_n; w0 = w_hs_n;
            e = model(1'b1, 12'h010, d, 4'hF);
            run_txn(1'b1, 12'h010, d, 4'hF, 0, r, done, st);
            vectors++;
            if (!done || r !== e) begin miscompares++; $display("FAIL t3_rsp%0d got=%h exp=%h", k, r, e); end
            vectors++;
            if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin
                miscompares++; $display("FAIL t3_beats%0d aw=%0d w=%0d exp=1/1", k, aw_hs_n - aw0, w_hs_n - w0);
            end
            vectors++;
            if (b_first_cyc <= aw_hs_cyc || b_first_cyc <= w_hs_cyc || (aw_hs_cyc < w_hs_cyc) != (k == 0)) begin
                miscompares++;
                $display("FAIL t3_order%0d aw_cyc=%0d w_cyc=%0d b_cyc=%0d", k, aw_hs_cyc, w_hs_cyc, b_first_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t r, e; bit done, st; logic [31:0] d;
        set_nominal();
        bresp_val = 2'b01;
        d = $urandom;
        e = model(1'b1, 12'h020, d, 4'b0101);
        run_txn(1'b1, 12'h020, d, 4'b0101, 5, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t4_rsp got=%h exp=%h", r, e); end
        vectors++;
        if (st !== 1'b1) begin miscompares++; $display("FAIL t4_hold_stable got=%b exp=1", st); end
        bresp_val = 2'b00;
        e = model(1'b0, 12'h020, '0, '0);
        run_txn(1'b0, 12'h020, '0, '0, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t4_second got=%h exp=%h", r, e); end
    endtask

    task automatic test_timeout();
        rsp_t r, e; bit done, st; int a0;
        for (int k = 0; k < 2; k++) begin
            set_nominal();
            ar_lat = (k == 0) ? -1 : TO - 1;
            a0 = arv_n;
            e = model(1'b0, 12'h004, '0, '0);
            run_txn(1'b0, 12'h004, '0, '0, 0, r, done, st);
            vectors++;
            if (!done || r !== e) begin miscompares++; $display("FAIL t5_ar_rsp%0d got=%h exp=%h", k, r, e); end
            vectors++;
            if (arv_n - a0 != TO) begin miscompares++; $display("FAIL t5_arvalid_cycles%0d got=%0d exp=%0d", k, arv_n - a0, TO); end
        end
        set_nominal();
        b_lat = -1;
        e = model(1'b1, 12'h030, 32'hCAFE_F00D, 4'hF);
        run_txn(1'b1, 12'h030, 32'hCAFE_F00D, 4'hF, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t5_b_timeout got=%h exp=%h", r, e); end
        vectors++;
        if (axi_bready !== 1'b0) begin miscompares++; $display("FAIL t5_bready_drop got=%b exp=0", axi_bready); end
    endtask

    task automatic test_errors_reset();
        rsp_t r, e; bit done, st, quiet; int n;
        set_nominal();
        bid_val = 8'h11;
        e = model(1'b1, 12'h008, 32'h1234_5678, 4'hF);
        run_txn(1'b1, 12'h008, 32'h1234_5678, 4'hF, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t6_bid_err got=%h exp=%h", r, e); end
        set_nominal();
        rresp_val = 2'b10;
        e = model(1'b0, 12'h008, '0, '0);
        run_txn(1'b0, 12'h008, '0, '0, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t6_rresp got=%h exp=%h", r, e); end
        set_nominal();
        r_lat = -1;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008;
        n = 0;
        while (!axi_rready && n < 100) begin
            @(negedge aclk);
            if (!cmd_ready) cmd_valid = 1'b0;
            n++;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (!axi_rready) begin miscompares++; $display("FAIL t6_reach_r got=%b exp=1", axi_rready); end
        #2 arstn = 1'b0;
        #1;
        vectors++;
        if (dut_outs !== '0) begin miscompares++; $display("FAIL t6_async_reset got=%h exp=0", dut_outs); end
        @(negedge aclk); arstn = 1'b1;
        r_lat = 0;
        quiet = 1'b1;
        repeat (4) begin @(negedge aclk); if (rsp_valid) quiet = 1'b0; end
        vectors++;
        if (quiet !== 1'b1) begin miscompares++; $display("FAIL t6_no_lost_rsp got=%b exp=1", quiet); end
        e = model(1'b0, 12'h008, '0, '0);
        run_txn(1'b0, 12'h008, '0, '0, 0, r, done, st);
        vectors++;
        if (!done || r !== e) begin miscompares++; $display("FAIL t6_after_reset got=%h exp=%h", r, e); end
    endtask

    function automatic int rand_lat();
        return ($urandom_range(0, 11) == 0) ? 20 : int'($urandom_range(0, 4));
    endfunction

    task automatic test_random();
        rsp_t r, e; bit done, st, w; logic [11:0] a; logic [31:0] d; logic [3:0] s;
        int unsigned wi; int hold;
        for (int k = 0; k < 40; k++) begin
            aw_lat = rand_lat(); w_lat = rand_lat(); ar_lat = rand_lat();
            b_lat = rand_lat(); r_lat = rand_lat();
            bid_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h5A;
            rid_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h5A;
            bresp_val = 2'($urandom); rresp_val = 2'($urandom);
            w = 1'($urandom_range(0, 1));
            wi = $urandom_range(4, 63);
            a = 12'(wi << 2);
            d = $urandom; s = 4'($urandom);
            hold = int'($urandom_range(0, 3));
            e = model(w, a, d, s);
            run_txn(w, a, d, s, hold, r, done, st);
            vectors++;
            if (!done || !st || r !== e) begin
                miscompares++;
                $display("FAIL rnd%0d w=%0d a=%h got=%h done=%0d stable=%0d exp=%h", k, w, a, r, done, st, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_aw_w_order();
        test_back_to_back();
        test_timeout();
        test_errors_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
